// File: rtl/mii_rx_ctrl_parser_pkg.sv
// rtl/mii_rx_ctrl_parser_pkg.sv - shared constants and types for the MII receive control parser
package mii_rx_ctrl_parser_pkg;

  // Frame-ID width shared with the transmit framer
  localparam int FID_LEN = 8;

  // Addresses and preamble symbols shared with the transmit framer
  localparam logic [47:0] NODE_MAC     = 48'h0010_A47B_EA80;
  localparam logic [47:0] BCAST_MAC    = 48'hFFFF_FFFF_FFFF;
  localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
  localparam logic [3:0]  SFD_NIB      = 4'hD;

  // Control frame EtherType and command codes
  localparam logic [15:0] CTRL_ETYPE = 16'h88B5;
  localparam logic [7:0]  CMD_STOP   = 8'h00;
  localparam logic [7:0]  CMD_START  = 8'h01;

  // CRC-32: reflected polynomial and the good-frame residue in normal bit order
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704_DD7B;

  // Legal frame length in nibbles, DA through FCS (64..1518 bytes)
  localparam logic [11:0] MIN_NIBS = 12'd128;
  localparam logic [11:0] MAX_NIBS = 12'd3036;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_PAY,
    S_CHK,
    S_DROP,
    S_DROP_SILENT
  } state_t;

  // The CRC register shifts right, so its residue is the bit-mirror of the textbook value
  function automatic logic [31:0] bit_rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/CRC_Module.sv
// rtl/CRC_Module.sv - nibble-serial Ethernet CRC-32, least-significant bit first
module CRC_Module
  import mii_rx_ctrl_parser_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        init,
  input  logic        enable,
  input  logic [3:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_next;

  // Fold four data bits into the reflected CRC, bit 0 of the nibble first
  always_comb begin
    crc_next = crc;
    for (int i = 0; i < 4; i++) begin
      if (crc_next[0] ^ data[i]) crc_next = (crc_next >> 1) ^ CRC_POLY_REFL;
      else                       crc_next = crc_next >> 1;
    end
  end

  // CRC register: init preloads all-ones, enable advances one nibble
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)       crc <= '1;
    else if (init)   crc <= '1;
    else if (enable) crc <= crc_next;
  end

endmodule

// File: rtl/mii_rx_ctrl_parser.sv
// rtl/mii_rx_ctrl_parser.sv - MII receive parser committing start/frameid from good control frames
module mii_rx_ctrl_parser
  import mii_rx_ctrl_parser_pkg::*;
#(
  parameter int          FRAMEID_LEN = FID_LEN,
  parameter logic [47:0] MAC_ADDR    = NODE_MAC,
  parameter logic [15:0] CTRL_TYPE   = CTRL_ETYPE
) (
  input  logic                   phy_rxclk,
  input  logic                   reset_n,
  input  logic [3:0]             phy_rxd,
  input  logic                   phy_rxdv,
  input  logic                   phy_rxer,
  output logic                   start,
  output logic [FRAMEID_LEN-1:0] frameid,
  output logic                   frame_ok,
  output logic                   frame_err,
  output logic [7:0]             err_cnt
);

  localparam int FID_BYTES = (FRAMEID_LEN + 7) / 8;

  state_t state, state_next;
  logic [11:0] nib_cnt;
  logic [3:0]  lo_nib;
  logic [7:0]  type_hi, cmd;
  logic [8*FID_BYTES-1:0] shadow;
  logic        da_mac, da_bc, fault, armed;
  logic [31:0] crc;
  logic        crc_init, crc_en, commit, reject;
  logic        in_frame, byte_done, da_mac_now, da_bc_now, good;
  logic [7:0]  rx_byte;
  logic [10:0] byte_idx;

  function automatic logic [7:0] addr_byte(input logic [47:0] a, input logic [2:0] k);
    case (k)
      3'd0:    return a[47:40];
      3'd1:    return a[39:32];
      3'd2:    return a[31:24];
      3'd3:    return a[23:16];
      3'd4:    return a[15:8];
      default: return a[7:0];
    endcase
  endfunction

  assign in_frame   = (state == S_HDR || state == S_PAY) && phy_rxdv;
  assign byte_done  = in_frame && nib_cnt[0];
  assign rx_byte    = {phy_rxd, lo_nib};
  assign byte_idx   = nib_cnt[11:1];
  assign da_mac_now = da_mac && (rx_byte == addr_byte(MAC_ADDR, byte_idx[2:0]));
  assign da_bc_now  = da_bc && (rx_byte == 8'hFF);
  assign good       = (bit_rev32(crc) == CRC_RESIDUE) && !nib_cnt[0] &&
                      (nib_cnt >= MIN_NIBS) && (nib_cnt <= MAX_NIBS) && !fault &&
                      (cmd == CMD_START || cmd == CMD_STOP);

  CRC_Module u_crc (
    .Clk    (phy_rxclk),
    .Reset  (~reset_n),
    .init   (crc_init),
    .enable (crc_en),
    .data   (phy_rxd),
    .crc    (crc)
  );

  // State register
  always_ff @(posedge phy_rxclk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next state, CRC control and commit/reject decisions
  always_comb begin
    state_next = state;
    crc_init   = 1'b0;
    crc_en     = 1'b0;
    commit     = 1'b0;
    reject     = 1'b0;
    case (state)
      S_IDLE: if (phy_rxdv && armed) state_next = S_PRE;
      S_PRE: begin
        crc_init = 1'b1;
        if (!phy_rxdv)                   state_next = S_IDLE;
        else if (phy_rxd == SFD_NIB)      state_next = S_HDR;
        else if (phy_rxd != PREAMBLE_NIB) state_next = S_DROP;
      end
      S_HDR, S_PAY: begin
        crc_en = phy_rxdv;
        if (!phy_rxdv)              state_next = S_CHK;
        else if (nib_cnt >= MAX_NIBS) state_next = S_DROP;
        else if (state == S_HDR && byte_done) begin
          if (byte_idx == 11'd5 && !(da_mac_now || da_bc_now))        state_next = S_DROP_SILENT;
          else if (byte_idx == 11'd13 && {type_hi, rx_byte} != CTRL_TYPE) state_next = S_DROP_SILENT;
          else if (byte_idx == 11'd13)                               state_next = S_PAY;
        end
      end
      S_CHK: begin
        state_next = S_IDLE;
        commit     = good;
        reject     = !good;
      end
      S_DROP:        if (!phy_rxdv) state_next = S_CHK;
      S_DROP_SILENT: if (!phy_rxdv) state_next = S_IDLE;
      default:       state_next = S_IDLE;
    endcase
  end

  // Byte assembly, header match flags, command/frame-ID shadow and sticky fault
  always_ff @(posedge phy_rxclk or negedge reset_n) begin
    if (!reset_n) begin
      nib_cnt <= '0;
      lo_nib  <= '0;
      type_hi <= '0;
      cmd     <= '0;
      shadow  <= '0;
      da_mac  <= 1'b0;
      da_bc   <= 1'b0;
      fault   <= 1'b0;
      armed   <= 1'b0;
    end else begin
      if (!phy_rxdv) armed <= 1'b1;
      if (state == S_PRE) begin
        nib_cnt <= '0;
        da_mac  <= 1'b1;
        da_bc   <= 1'b1;
        fault   <= 1'b0;
      end else if (in_frame) begin
        nib_cnt <= nib_cnt + 12'd1;
        if (phy_rxer) fault <= 1'b1;
        if (!nib_cnt[0]) begin
          lo_nib <= phy_rxd;
        end else begin
          if (byte_idx < 11'd6) begin
            da_mac <= da_mac_now;
            da_bc  <= da_bc_now;
          end
          if (byte_idx == 11'd12) type_hi <= rx_byte;
          if (byte_idx == 11'd14) cmd <= rx_byte;
          for (int j = 0; j < FID_BYTES; j++)
            if (byte_idx == 11'(15 + j)) shadow[8*j +: 8] <= rx_byte;
        end
      end else if (state == S_DROP) begin
        fault <= 1'b1;
      end
    end
  end

  // Committed outputs, status pulses and saturating error counter
  always_ff @(posedge phy_rxclk or negedge reset_n) begin
    if (!reset_n) begin
      start     <= 1'b0;
      frameid   <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      frame_ok  <= commit;
      frame_err <= reject;
      if (commit) begin
        start   <= cmd[0];
        frameid <= shadow[FRAMEID_LEN-1:0];
      end
      if (reject && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_mii_rx_ctrl_parser.sv
// tb/tb_mii_rx_ctrl_parser.sv - scoreboard bench for the MII receive control parser
module tb_mii_rx_ctrl_parser;

  localparam logic [47:0] MY_MAC = 48'h0010_A47B_EA80;
  localparam logic [47:0] BC_MAC = 48'hFFFF_FFFF_FFFF;
  localparam logic [15:0] CTYPE  = 16'h88B5;

  logic       phy_rxclk = 1'b0;
  logic       reset_n   = 1'b0;
  logic [3:0] phy_rxd   = 4'h0;
  logic       phy_rxdv  = 1'b0;
  logic       phy_rxer  = 1'b0;
  logic       start, frame_ok, frame_err;
  logic [7:0] frameid, err_cnt;

  always #5 phy_rxclk = ~phy_rxclk;

  mii_rx_ctrl_parser dut (
    .phy_rxclk (phy_rxclk),
    .reset_n   (reset_n),
    .phy_rxd   (phy_rxd),
    .phy_rxdv  (phy_rxdv),
    .phy_rxer  (phy_rxer),
    .start     (start),
    .frameid   (frameid),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_cnt   (err_cnt)
  );

  typedef struct {int kind; logic st; logic [7:0] fid; logic [7:0] cnt; int due;} exp_t;
  typedef struct {logic ok; logic err; logic st; logic [7:0] fid; logic [7:0] cnt; int cyc;} obs_t;

  exp_t       exp_q[$];
  obs_t       obs_q[$];
  logic [7:0] frm[$];
  logic [7:0] cur_cmd, cur_fid;
  logic       m_start;
  logic [7:0] m_fid, m_cnt;
  int         cyc = 0;
  int         passed = 0;
  int         total = 0;

  always @(posedge phy_rxclk) cyc <= cyc + 1;

  always @(negedge phy_rxclk)
    if (frame_ok || frame_err)
      obs_q.push_back('{frame_ok, frame_err, start, frameid, err_cnt, cyc});

  task automatic check(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge phy_rxclk);
  endtask

  task automatic build(input logic [47:0] da, input logic [15:0] typ, input logic [7:0] cmd,
                       input logic [7:0] fid, input int plen);
    logic [31:0] c;
    logic [7:0]  b;
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(da[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(8'h20 + 8'(i));
    frm.push_back(typ[15:8]);
    frm.push_back(typ[7:0]);
    frm.push_back(cmd);
    frm.push_back(fid);
    for (int i = 2; i < plen; i++) frm.push_back(8'(i * 7 + 3));
    c = '1;
    foreach (frm[i]) begin
      b = frm[i];
      for (int k = 0; k < 8; k++) c = (c[0] ^ b[k]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
    cur_cmd = cmd;
    cur_fid = fid;
  endtask

  // kind: 0 = no event expected, 1 = commit, 2 = frame_err
  task automatic send(input int kind, input int rxer_nib, input bit odd, input int rst_nib);
    logic [3:0] nibs[$];
    exp_t e;
    for (int i = 0; i < 15; i++) nibs.push_back(4'h5);
    nibs.push_back(4'hD);
    foreach (frm[i]) begin
      nibs.push_back(frm[i][3:0]);
      nibs.push_back(frm[i][7:4]);
    end
    if (odd) nibs.push_back(4'hA);
    foreach (nibs[i]) begin
      @(negedge phy_rxclk);
      phy_rxdv = 1'b1;
      phy_rxd  = nibs[i];
      phy_rxer = (i == rxer_nib);
      if (i == rst_nib) begin
        #2 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        m_start = 1'b0;
        m_fid   = 8'h00;
        m_cnt   = 8'h00;
        check(start, 0, "async rst start");
        check(frameid, 0, "async rst frameid");
        check(err_cnt, 0, "async rst err_cnt");
      end
    end
    @(negedge phy_rxclk);
    phy_rxdv = 1'b0;
    phy_rxd  = 4'h0;
    phy_rxer = 1'b0;
    if (kind == 1) begin
      m_start = cur_cmd[0];
      m_fid   = cur_fid;
    end
    if (kind == 2 && m_cnt != 8'hFF) m_cnt++;
    if (kind != 0) begin
      e = '{kind, m_start, m_fid, m_cnt, cyc + 2};
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    exp_t e;
    obs_t o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(obs_q.size() > 0, 1, "event seen");
      if (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        check(o.ok, e.kind == 1, "frame_ok");
        check(o.err, e.kind == 2, "frame_err");
        check(o.cyc, e.due, "latency");
        check(o.st, e.st, "start");
        check(o.fid, e.fid, "frameid");
        check(o.cnt, e.cnt, "err_cnt");
      end
    end
    check(obs_q.size(), 0, "stray events");
    obs_q.delete();
  endtask

  initial begin
    m_start = 1'b0;
    m_fid   = 8'h00;
    m_cnt   = 8'h00;
    idle(3);
    check(start, 0, "reset start");
    check(frameid, 0, "reset frameid");
    check(frame_ok, 0, "reset frame_ok");
    check(frame_err, 0, "reset frame_err");
    check(err_cnt, 0, "reset err_cnt");
    reset_n = 1'b1;
    idle(3);

    build(MY_MAC, CTYPE, 8'h01, 8'h5A, 46); send(1, -1, 0, -1); idle(8); drain();
    build(BC_MAC, CTYPE, 8'h00, 8'h07, 46); send(1, -1, 0, -1); idle(8); drain();

    build(MY_MAC, CTYPE, 8'h01, 8'h99, 46);
    frm[frm.size() - 3] = frm[frm.size() - 3] ^ 8'h04;
    send(2, -1, 0, -1); idle(8); drain();
    check(start, 0, "fcs hold start");
    check(frameid, 8'h07, "fcs hold frameid");

    build(48'h0010_A47B_EA81, CTYPE, 8'h01, 8'h98, 46); send(0, -1, 0, -1); idle(8); drain();
    build(MY_MAC, 16'h0800, 8'h01, 8'h97, 46); send(0, -1, 0, -1); idle(8); drain();
    check(err_cnt, 1, "silent err_cnt");
    check(start, 0, "silent start");
    check(frameid, 8'h07, "silent frameid");

    build(MY_MAC, CTYPE, 8'h01, 8'h61, 46); send(2, 16 + 2 * 30, 0, -1); idle(8); drain();
    build(MY_MAC, CTYPE, 8'h01, 8'h62, 42); send(2, -1, 0, -1); idle(8); drain();
    build(MY_MAC, CTYPE, 8'h01, 8'h63, 46); send(2, -1, 1, -1); idle(8); drain();
    build(MY_MAC, CTYPE, 8'h02, 8'h64, 46); send(2, -1, 0, -1); idle(8); drain();
    build(MY_MAC, CTYPE, 8'h01, 8'h3C, 1500); send(1, -1, 0, -1); idle(8); drain();
    build(MY_MAC, CTYPE, 8'h00, 8'h4D, 1501); send(2, -1, 0, -1); idle(8); drain();
    check(start, 1, "oversize hold start");

    build(MY_MAC, CTYPE, 8'h00, 8'h11, 46); send(1, -1, 0, -1);
    build(BC_MAC, CTYPE, 8'h01, 8'h22, 46); send(1, -1, 0, -1); idle(8); drain();

    build(MY_MAC, CTYPE, 8'h01, 8'h44, 46); send(0, -1, 0, 16 + 2 * 20);
    build(MY_MAC, CTYPE, 8'h01, 8'h55, 46); send(1, -1, 0, -1); idle(8); drain();
    check(start, 1, "post-reset start");
    check(frameid, 8'h55, "post-reset frameid");

    build(MY_MAC, CTYPE, 8'h01, 8'h66, 46);
    while (frm.size() > 16) void'(frm.pop_back());
    for (int i = 0; i < 300; i++) begin
      send(2, -1, 0, -1);
      idle(3);
      drain();
    end
    check(err_cnt, 8'hFF, "err_cnt saturated");
    check(start, 1, "saturation hold start");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mii_rx_ctrl_parser.md
# mii_rx_ctrl_parser

Receive-side MII parser that sits directly upstream of the transmit framer. It consumes nibbles from the Ethernet PHY receive interface, recognises control frames addressed to this node, and checks their CRC-32. On each good frame it updates the `start` enable and the `frameid` value that the transmit framer uses to gate and tag its outgoing frames. Bad, foreign or truncated frames never change these outputs.

## Interface
- `FRAMEID_LEN`, 8: width of `frameid`; equal to the shared frame-ID length constant; 1..32.
- `MAC_ADDR`, 48'h0010_A4_7B_EA_80: this node's address; `MAC_ADDR[47:40]` is the first DA byte on the wire.
- `CTRL_TYPE`, 16'h88B5: EtherType of control frames; high byte first on the wire.
- `phy_rxclk` in 1: MII receive clock, 2.5/25 MHz; all logic runs on its rising edge.
- `reset_n` in 1: asynchronous active-low reset.
- `phy_rxd` in 4: MII receive nibble; the low nibble of each byte arrives first.
- `phy_rxdv` in 1: MII receive data valid.
- `phy_rxer` in 1: MII receive error.
- `start` out 1: transmit enable level.
- `frameid` out FRAMEID_LEN: frame ID committed by the last good control frame.
- `frame_ok` out 1: one-cycle pulse when a good control frame is committed.
- `frame_err` out 1: one-cycle pulse when a frame addressed to this node is dropped.
- `err_cnt` out 8: saturating count of `frame_err` pulses.

## Operation
- Frame layout after the SFD: DA(6), SA(6), TYPE(2), payload (≥46 bytes), FCS(4).
- Payload byte 0 is the command: 0x01 means start, 0x00 means stop; any other value is an error.
- Payload bytes 1..ceil(FRAMEID_LEN/8) carry the frame ID, least-significant byte first; excess bits are ignored.
- Bytes are assembled from nibble pairs as {second nibble, first nibble}.
- FSM states:
  - IDLE: wait for `phy_rxdv`=1.
  - PRE: accept nibbles of 0x5. Nibble 0xD moves to HDR. Any other nibble moves to DROP.
  - HDR: capture DA, SA and TYPE.
    - DA is neither MAC_ADDR nor all-ones → DROP_SILENT.
    - TYPE ≠ CTRL_TYPE → DROP_SILENT.
  - PAY: capture the command and shadow frame ID; continue to the end of the frame.
  - CHK: entered on the `phy_rxdv` falling edge. Commit when all of the following hold:
    - the CRC residue equals 32'hC704DD7B;
    - the byte count from DA through FCS is between 64 and 1518 inclusive;
    - the byte count is whole (even nibble count);
    - no `phy_rxer` was seen;
    - the command is legal.
    Otherwise go to DROP.
  - DROP: wait for `phy_rxdv`=0, then pulse `frame_err` and return to IDLE.
  - DROP_SILENT: wait for `phy_rxdv`=0, then return to IDLE with no pulse.
- Commit sets `start` from the command bit, loads `frameid` from the shadow register, and pulses `frame_ok`.
- The CRC runs over DA through FCS. It is initialised in PRE and enabled only in HDR and PAY.
- `phy_rxer`=1 in HDR or PAY sets a sticky error flag; the frame still runs to the end of `phy_rxdv`.
- The nibble counter is 12 bits. When it exceeds 3036 nibbles the FSM moves to DROP; it does not wrap.
- `err_cnt` holds at 255.

## Timing
- Reset values: `start`=0, `frameid`=0, `frame_ok`=0, `frame_err`=0, `err_cnt`=0, FSM=IDLE, shadow registers=0.
- Latency for a good frame:
  - `phy_rxdv` is sampled low at edge N.
  - The FSM is in CHK after edge N.
  - `start`, `frameid` and `frame_ok` update at edge N+1.
  - `frame_ok` is high for exactly one cycle.
- Latency for an errored frame: `frame_err` pulses one cycle after `phy_rxdv` is sampled low.
- `phy_rxdv` rising again while in CHK or DROP is ignored until IDLE has been seen for one cycle.
- `reset_n` assertion mid-frame clears everything asynchronously. After release the FSM waits in IDLE; it does not resynchronise into the current frame.
- Back-to-back frames with a 1-cycle IDLE gap must both be processed.

## Structure
- Shared package/include holds:
  - the frame-ID length;
  - the MAC addresses and preamble constants also used by the transmit framer;
  - CTRL_TYPE;
  - the command codes;
  - the CRC residue.
- Sub-module: reuse the existing `CRC_Module` (nibble CRC-32) for the receive CRC.
  - Its `Reset` input is driven by `~reset_n`.
  - Its `Clk` is driven by `phy_rxclk`.

## Test plan
- Good start frame, 64 bytes, DA=MAC_ADDR, cmd 0x01, frame ID 0x5A → `start`=1, `frameid`=0x5A and a 1-cycle `frame_ok` at rxdv-fall+1.
- Good stop frame to broadcast DA, frame ID 0x07 → `start`=0, `frameid`=0x07, `frame_ok` pulse.
- Single-bit FCS corruption → `frame_err` pulse, `err_cnt`=1, `start` and `frameid` unchanged.
- Foreign DA, or TYPE=0x0800 → no pulses, outputs unchanged, `err_cnt` unchanged.
- Each of the following → `frame_err` and no commit:
  - `phy_rxer` asserted for one nibble in the payload;
  - a 60-byte frame;
  - an odd nibble count.
- `reset_n` low mid-payload of a start frame → `start`=0; a following good frame with a 1-cycle gap commits normally.
- 300 bad frames → `err_cnt` saturates at 255.
